prbs31_sync_checker: RTL and testbench
======================================

# prbs31_sync_checker

Self-synchronising PRBS31 (x^31 + x^28 + 1) receiver checker. It sits at the far end of the channel model, downstream of the channel/slicer, and consumes the recovered serial bit stream. Unlike a seed-locked checker, it acquires sequence alignment from the incoming data itself, so the generator seed, pipeline delay and channel latency do not need to be known. After lock it counts bits and bit errors, and it detects loss of lock.

## Interface
- Parameters:
- VERIFY_BITS, 64: consecutive correct predictions required before declaring lock.
- WINDOW_BITS, 1024: length of the lock-monitoring window, in valid bits.
- ERR_THRESH, 64: a window that ends with more than this many errors declares loss of lock.
- Ports:
- clk  in  1  sole clock; everything is on the rising edge.
- rst  in  1  reset, synchronous and active-high. This is fixed.
- data_in  in  1  received bit.
- data_in_valid  in  1  qualifies data_in. Nothing advances while it is low.
- locked  out  1  high while in state LOCKED.
- total_bits  out  32  valid bits counted while LOCKED.
- total_bit_errors  out  32  mismatches counted while LOCKED.
- lock_loss_count  out  16  number of LOCKED→FILL transitions.
- state  out  2  current FSM state, for debug.

## Operation
- LFSR: 31-bit register sr. The prediction is pred = sr[30] ^ sr[27]. When a bit is accepted, sr shifts left and the shifted-in bit enters at bit 0.
- FSM states are FILL=0, VERIFY=1, LOCKED=2. State 3 is illegal and goes to FILL.
- FILL: each valid bit shifts data_in, not pred, into sr, and fill_cnt increments. After the 31st valid bit, go to VERIFY with ver_cnt=0.
- VERIFY: each valid bit shifts data_in into sr and compares data_in against pred.
  - On a mismatch, go to FILL with fill_cnt=0.
  - On a match, ver_cnt increments. When the VERIFY_BITS-th consecutive match arrives, go to LOCKED and clear the window counters.
- LOCKED: each valid bit shifts pred, not data_in, into sr, so channel errors do not corrupt the reference.
  - total_bits increments on every valid bit.
  - total_bit_errors increments when data_in != pred.
  - win_cnt and win_err track the current window.
- Window end: on the WINDOW_BITS-th valid bit, evaluate win_err including the current bit.
  - If it is greater than ERR_THRESH, go to FILL, increment lock_loss_count, and clear fill_cnt.
  - Otherwise clear win_cnt and win_err and stay in LOCKED.
- total_bits, total_bit_errors and lock_loss_count saturate at all-ones and never wrap. They hold their values across relock and clear only on rst.
- Counter widths: fill_cnt is 5 bits, ver_cnt is clog2(VERIFY_BITS+1), win_cnt is clog2(WINDOW_BITS+1), and win_err is clog2(WINDOW_BITS+1).

## Timing
- Reset: when rst is high at an edge, set state=FILL, locked=0, all counters to 0, and sr=0.
  - rst has priority over data_in_valid.
  - rst asserted mid-lock takes effect on that edge, with no drain.
- All outputs are registered. They reflect a sample one cycle after the edge where data_in_valid was high.
- Lock latency: with a clean stream, locked rises on the edge that accepts valid bit 31+VERIFY_BITS, which is bit 95 with defaults. It is visible in the following cycle.
- The first bit counted in total_bits is the first valid bit after locked rises. Verify bits are not counted.
- Gaps in data_in_valid: all state, sr and counters hold. Gaps do not count toward the window.
- Window-end evaluation and the current bit's error are resolved on the same edge.
- locked falls on the edge that completes the failing window.
- An all-zero fill locks falsely on a stuck-at-0 input, because the predictions are 0 and match. This is accepted, and the bench checks for it.

## Structure
- A shared package prbs_pkg holds the PRBS31 constants: width 31, taps 30 and 27, and the state encoding. prbs31 and prbs31_checker reuse it.
- One sub-module, prbs31_lfsr_step, is natural. It is combinational: sr in, bit in, load-select in; next sr out and pred out. It gives one tap definition shared with the generator.

## Test plan
- prbs31 generator with an arbitrary non-default seed, continuous valid → locked high after valid bit 95. After 10000 more bits: total_bits=10000, total_bit_errors=0.
- Locked, then invert one bit → total_bit_errors=1, locked stays 1, and the next bit predicts correctly (no error propagation).
- Locked, then invert 65 bits within one 1024-bit window → locked falls at the window end and lock_loss_count=1. Relock occurs 95 clean bits later.
- Invert a bit during VERIFY, e.g. valid bit 50 → returns to FILL. locked rises at bit 50+95=145, not 95.
- Toggle valid randomly at 30% duty → lock bit count and all counter values are identical to the continuous case.
- Assert rst for 1 cycle mid-lock → the next cycle shows locked=0, all counts 0 and state=FILL. Relock occurs after 95 valid bits.

Source files
------------

// File: rtl/prbs_pkg.sv
// prbs_pkg: PRBS31 (x^31 + x^28 + 1) width, tap positions and checker state encoding
package prbs_pkg;
    localparam int PRBS_W = 31;
    localparam int TAP_A = 30;
    localparam int TAP_B = 27;
    typedef enum logic [1:0] {FILL = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;
endpackage

// File: rtl/prbs31_lfsr_step.sv
// prbs31_lfsr_step: one PRBS31 shift; sr/bit_in/sel_pred in, sr_next (shifts in pred when sel_pred, else bit_in) and pred out
module prbs31_lfsr_step
    import prbs_pkg::*;
(
    input  logic [PRBS_W-1:0] sr,
    input  logic              bit_in,
    input  logic              sel_pred,
    output logic [PRBS_W-1:0] sr_next,
    output logic              pred
);
    assign pred    = sr[TAP_A] ^ sr[TAP_B];
    assign sr_next = {sr[PRBS_W-2:0], sel_pred ? pred : bit_in};
endmodule

// File: rtl/prbs31_sync_checker.sv
// prbs31_sync_checker: self-synchronising PRBS31 checker; clk/rst/data_in/data_in_valid in, locked/total_bits/total_bit_errors/lock_loss_count/state out
module prbs31_sync_checker
    import prbs_pkg::*;
#(
    parameter int VERIFY_BITS = 64,
    parameter int WINDOW_BITS = 1024,
    parameter int ERR_THRESH  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_in,
    input  logic        data_in_valid,
    output logic        locked,
    output logic [31:0] total_bits,
    output logic [31:0] total_bit_errors,
    output logic [15:0] lock_loss_count,
    output logic [1:0]  state
);
    localparam int VW = $clog2(VERIFY_BITS + 1);
    localparam int WW = $clog2(WINDOW_BITS + 1);
    state_t            st;
    logic [PRBS_W-1:0] sr;
    logic [PRBS_W-1:0] sr_next;
    logic              pred;
    logic              err;
    logic [4:0]        fill_cnt;
    logic [VW-1:0]     ver_cnt;
    logic [WW-1:0]     win_cnt;
    logic [WW-1:0]     win_err;
    logic [WW-1:0]     win_err_n;
    prbs31_lfsr_step u_step (
        .sr      (sr),
        .bit_in  (data_in),
        .sel_pred(st == LOCKED),
        .sr_next (sr_next),
        .pred    (pred)
    );
    assign err       = data_in ^ pred;
    assign win_err_n = win_err + WW'(err);
    assign state     = st;
    always_ff @(posedge clk) begin
        if (rst) begin
            st               <= FILL;
            locked           <= 1'b0;
            sr               <= '0;
            fill_cnt         <= '0;
            ver_cnt          <= '0;
            win_cnt          <= '0;
            win_err          <= '0;
            total_bits       <= '0;
            total_bit_errors <= '0;
            lock_loss_count  <= '0;
        end else if (data_in_valid) begin
            sr <= sr_next;
            case (st)
                FILL: begin
                    fill_cnt <= (fill_cnt == 5'(PRBS_W - 1)) ? '0 : fill_cnt + 5'd1;
                    if (fill_cnt == 5'(PRBS_W - 1)) begin
                        st      <= VERIFY;
                        ver_cnt <= '0;
                    end
                end
                VERIFY: begin
                    if (err) begin
                        st       <= FILL;
                        fill_cnt <= '0;
                    end else if (ver_cnt == VW'(VERIFY_BITS - 1)) begin
                        st      <= LOCKED;
                        locked  <= 1'b1;
                        win_cnt <= '0;
                        win_err <= '0;
                    end else begin
                        ver_cnt <= ver_cnt + VW'(1);
                    end
                end
                LOCKED: begin
                    total_bits       <= total_bits + 32'(total_bits != '1);
                    total_bit_errors <= total_bit_errors + 32'(err && total_bit_errors != '1);
                    win_cnt          <= (win_cnt == WW'(WINDOW_BITS - 1)) ? '0 : win_cnt + WW'(1);
                    win_err          <= (win_cnt == WW'(WINDOW_BITS - 1)) ? '0 : win_err_n;
                    if (win_cnt == WW'(WINDOW_BITS - 1) && win_err_n > WW'(ERR_THRESH)) begin
                        st              <= FILL;
                        locked          <= 1'b0;
                        fill_cnt        <= '0;
                        lock_loss_count <= lock_loss_count + 16'(lock_loss_count != '1);
                    end
                end
                default: begin
                    st       <= FILL;
                    locked   <= 1'b0;
                    fill_cnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_prbs31_sync_checker.sv
// tb_prbs31_sync_checker: table-driven scoreboard bench for prbs31_sync_checker
module tb_prbs31_sync_checker;
    typedef struct {
        logic rst_first;
        int   n;
        int   inv_from;
        int   inv_cnt;
        int   stride;
        int   duty;
        logic zero;
        logic locked;
        int   bits;
        int   errs;
        int   loss;
        int   st;
    } row_t;
    typedef struct {
        logic locked;
        int   bits;
        int   errs;
        int   loss;
        int   st;
    } exp_t;
    logic        clk;
    logic        rst;
    logic        data_in;
    logic        data_in_valid;
    logic        locked;
    logic [31:0] total_bits;
    logic [31:0] total_bit_errors;
    logic [15:0] lock_loss_count;
    logic [1:0]  state;
    logic [30:0] g;
    int          checks;
    int          passes;
    exp_t        q[$];
    row_t        tbl[20];
    prbs31_sync_checker dut (
        .clk             (clk),
        .rst             (rst),
        .data_in         (data_in),
        .data_in_valid   (data_in_valid),
        .locked          (locked),
        .total_bits      (total_bits),
        .total_bit_errors(total_bit_errors),
        .lock_loss_count (lock_loss_count),
        .state           (state)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic gen(output logic b);
        b = g[30] ^ g[27];
        g = {g[29:0], b};
    endtask
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask
    task automatic compare(input string tag);
        exp_t e;
        e = q.pop_front();
        chk({tag, ".locked"}, int'(locked), int'(e.locked));
        chk({tag, ".total_bits"}, int'(total_bits), e.bits);
        chk({tag, ".total_bit_errors"}, int'(total_bit_errors), e.errs);
        chk({tag, ".lock_loss_count"}, int'(lock_loss_count), e.loss);
        chk({tag, ".state"}, int'(state), e.st);
    endtask
    task automatic do_reset();
        g = 31'($urandom) | 31'd1;
        @(negedge clk);
        rst = 1'b1;
        data_in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask
    task automatic send(input int n, input int inv_from, input int inv_cnt, input int stride,
                        input int duty, input logic zero);
        int i;
        int guard;
        i = 0;
        guard = 0;
        while (i < n) begin
            logic v;
            logic b;
            v = (duty >= 100) || ($urandom_range(99) < 32'(duty));
            @(negedge clk);
            if (v) begin
                if (zero) b = 1'b0;
                else gen(b);
                if (i >= inv_from && i < inv_from + inv_cnt * stride && (i - inv_from) % stride == 0) b = ~b;
                i++;
            end else begin
                b = 1'($urandom_range(1));
            end
            data_in_valid = v;
            data_in = b;
            guard++;
            if (guard > 20 * n + 100) begin
                checks++;
                $display("FAIL send_budget: got %0d valid bits, expected %0d", i, n);
                break;
            end
        end
        @(negedge clk);
        data_in_valid = 1'b0;
    endtask
    initial begin
        checks = 0;
        passes = 0;
        rst = 1'b1;
        data_in = 1'b0;
        data_in_valid = 1'b0;
        g = 31'h1234567;
        tbl[0]  = '{1'b1, 94,    0,  0,  1, 100, 1'b0, 1'b0, 0,     0,   0, 1};
        tbl[1]  = '{1'b0, 1,     0,  0,  1, 100, 1'b0, 1'b1, 0,     0,   0, 2};
        tbl[2]  = '{1'b0, 10000, 0,  0,  1, 100, 1'b0, 1'b1, 10000, 0,   0, 2};
        tbl[3]  = '{1'b1, 95,    0,  0,  1, 100, 1'b0, 1'b1, 0,     0,   0, 2};
        tbl[4]  = '{1'b0, 100,   10, 1,  1, 100, 1'b0, 1'b1, 100,   1,   0, 2};
        tbl[5]  = '{1'b1, 95,    0,  0,  1, 100, 1'b0, 1'b1, 0,     0,   0, 2};
        tbl[6]  = '{1'b0, 1024,  0,  64, 3, 100, 1'b0, 1'b1, 1024,  64,  0, 2};
        tbl[7]  = '{1'b0, 1023,  0,  65, 3, 100, 1'b0, 1'b1, 2047,  129, 0, 2};
        tbl[8]  = '{1'b0, 1,     0,  0,  1, 100, 1'b0, 1'b0, 2048,  129, 1, 0};
        tbl[9]  = '{1'b0, 94,    0,  0,  1, 100, 1'b0, 1'b0, 2048,  129, 1, 1};
        tbl[10] = '{1'b0, 1,     0,  0,  1, 100, 1'b0, 1'b1, 2048,  129, 1, 2};
        tbl[11] = '{1'b1, 50,    49, 1,  1, 100, 1'b0, 1'b0, 0,     0,   0, 0};
        tbl[12] = '{1'b0, 94,    0,  0,  1, 100, 1'b0, 1'b0, 0,     0,   0, 1};
        tbl[13] = '{1'b0, 1,     0,  0,  1, 100, 1'b0, 1'b1, 0,     0,   0, 2};
        tbl[14] = '{1'b1, 94,    0,  0,  1, 30,  1'b0, 1'b0, 0,     0,   0, 1};
        tbl[15] = '{1'b0, 1,     0,  0,  1, 30,  1'b0, 1'b1, 0,     0,   0, 2};
        tbl[16] = '{1'b0, 3000,  500, 1, 1, 30,  1'b0, 1'b1, 3000,  1,   0, 2};
        tbl[17] = '{1'b1, 94,    0,  0,  1, 100, 1'b1, 1'b0, 0,     0,   0, 1};
        tbl[18] = '{1'b0, 1,     0,  0,  1, 100, 1'b1, 1'b1, 0,     0,   0, 2};
        tbl[19] = '{1'b0, 50,    0,  0,  1, 100, 1'b1, 1'b1, 50,    0,   0, 2};
        do_reset();
        q.push_back('{1'b0, 0, 0, 0, 0});
        compare("reset");
        for (int r = 0; r < 20; r++) begin
            if (tbl[r].rst_first) do_reset();
            q.push_back('{tbl[r].locked, tbl[r].bits, tbl[r].errs, tbl[r].loss, tbl[r].st});
            send(tbl[r].n, tbl[r].inv_from, tbl[r].inv_cnt, tbl[r].stride, tbl[r].duty, tbl[r].zero);
            compare($sformatf("row%0d", r));
        end
        q.push_back('{1'b1, 50, 0, 0, 2});
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            data_in_valid = 1'b0;
            data_in = 1'($urandom_range(1));
        end
        @(negedge clk);
        compare("idle_hold");
        do_reset();
        q.push_back('{1'b1, 20, 0, 0, 2});
        send(95, 0, 0, 1, 100, 1'b0);
        send(20, 0, 0, 1, 100, 1'b0);
        compare("pre_rst");
        q.push_back('{1'b0, 0, 0, 0, 0});
        @(negedge clk);
        rst = 1'b1;
        data_in_valid = 1'b1;
        gen(data_in);
        @(negedge clk);
        rst = 1'b0;
        data_in_valid = 1'b0;
        compare("mid_rst");
        q.push_back('{1'b0, 0, 0, 0, 1});
        send(94, 0, 0, 1, 100, 1'b0);
        compare("relock94");
        q.push_back('{1'b1, 0, 0, 0, 2});
        send(1, 0, 0, 1, 100, 1'b0);
        compare("relock95");
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
